// File: rtl/if_id_fetch_queue_if.sv
// Handshake/bus bundle between the fetch stage, the IF/ID fetch queue and the ID stage.
// master drives push/stall/flush controls; slave (the queue) drives ready, ID outputs and occupancy.
interface if_id_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            push_valid;
    logic            push_ready;
    logic [XLEN-1:0] PC_IF;
    logic [31:0]     INSTRUCTION_IF;
    logic            IF_ID_write;
    logic            flush;
    logic [XLEN-1:0] PC_ID;
    logic [31:0]     INSTRUCTION_ID;
    logic            valid_ID;
    logic [CW-1:0]   count;

    modport master (
        output push_valid, PC_IF, INSTRUCTION_IF, IF_ID_write, flush,
        input  push_ready, PC_ID, INSTRUCTION_ID, valid_ID, count
    );

    modport slave (
        input  push_valid, PC_IF, INSTRUCTION_IF, IF_ID_write, flush,
        output push_ready, PC_ID, INSTRUCTION_ID, valid_ID, count
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// Circular {PC, instruction} queue between IF and ID with a registered ID output stage.
// Define FETCHQ_BYPASS_EN to let a push into an empty, advancing queue go straight to the ID register.
module if_id_fetch_queue #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input logic                clk,
    input logic                reset,
    if_id_fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic [31:0]     instr_id_q, instr_id_d;
    logic            valid_id_q, valid_id_d;

    logic push_ready;
    logic push_acc;
    logic empty;
    logic bypass;
    logic pop;
    logic wr_en;

    always_comb begin
        // Ready looks only at registered occupancy, so a full queue never relies on a same-cycle pop.
        push_ready = (count_q < CW'(DEPTH));
        empty      = (count_q == '0);
        push_acc   = bus.push_valid && push_ready && !bus.flush;
`ifdef FETCHQ_BYPASS_EN
        bypass     = push_acc && empty && bus.IF_ID_write;
`else
        bypass     = 1'b0;
`endif
        pop        = bus.IF_ID_write && !empty && !bus.flush;
        wr_en      = push_acc && !bypass;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;

        if (bus.flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            pc_id_d    = '0;
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
        end else begin
            if (bus.IF_ID_write) begin
                if (!empty) begin
                    pc_id_d    = pc_mem_q[rd_ptr_q];
                    instr_id_d = instr_mem_q[rd_ptr_q];
                    valid_id_d = 1'b1;
                end else if (bypass) begin
                    pc_id_d    = bus.PC_IF;
                    instr_id_d = bus.INSTRUCTION_IF;
                    valid_id_d = 1'b1;
                end else begin
                    pc_id_d    = '0;
                    instr_id_d = NOP_INSTR;
                    valid_id_d = 1'b0;
                end
            end
            // Pointers wrap for free because DEPTH is a power of two.
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pc_id_q    <= '0;
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    // Storage carries no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]    <= bus.PC_IF;
            instr_mem_q[wr_ptr_q] <= bus.INSTRUCTION_IF;
        end
    end

    assign bus.push_ready     = push_ready;
    assign bus.PC_ID          = pc_id_q;
    assign bus.INSTRUCTION_ID = instr_id_q;
    assign bus.valid_ID       = valid_id_q;
    assign bus.count          = count_q;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed + random bench for if_id_fetch_queue against a queue-based reference model.
module tb_if_id_fetch_queue;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    bit   saw_40;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;

    if_id_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    if_id_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".PC_ID"},          bus.PC_ID,                         m_pc);
        chk({tag, ".INSTRUCTION_ID"}, bus.INSTRUCTION_ID,                m_instr);
        chk({tag, ".valid_ID"},       32'(bus.valid_ID),                 32'(m_valid));
        chk({tag, ".count"},          32'(bus.count),                    32'(mq.size()));
        chk({tag, ".push_ready"},     32'(bus.push_ready),               32'(mq.size() < DEPTH));
        $display("step %-8s pv=%0b pc_if=%h wr=%0b fl=%0b -> PC_ID=%h INSTR=%h valid=%0b count=%0d",
                 tag, bus.push_valid, bus.PC_IF, bus.IF_ID_write, bus.flush,
                 bus.PC_ID, bus.INSTRUCTION_ID, bus.valid_ID, bus.count);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = '0;
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    // One clock: drive inputs, advance the reference model by the same edge, compare after the edge.
    task automatic step(input bit pv, input logic [31:0] pc, input bit wr, input bit fl, input string tag);
        logic [31:0] ins;
        bit          acc;
        ent_t        e;
        ins                = $urandom;
        bus.push_valid     = pv;
        bus.PC_IF          = pc;
        bus.INSTRUCTION_IF = ins;
        bus.IF_ID_write    = wr;
        bus.flush          = fl;

        acc = pv && (mq.size() < DEPTH) && !fl;
        if (fl) begin
            mq.delete();
            m_pc = '0; m_instr = NOP; m_valid = 1'b0;
        end else begin
            if (wr) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_pc = e.pc; m_instr = e.instr; m_valid = 1'b1;
                end else if (acc && BYPASS) begin
                    m_pc = pc; m_instr = ins; m_valid = 1'b1;
                    acc = 1'b0;
                end else begin
                    m_pc = '0; m_instr = NOP; m_valid = 1'b0;
                end
            end
            if (acc) mq.push_back('{pc: pc, instr: ins});
        end

        @(posedge clk);
        #1;
        check_all(tag);
        if (bus.valid_ID && bus.PC_ID == 32'h40) saw_40 = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        saw_40   = 1'b0;
        bus.push_valid     = 1'b0;
        bus.PC_IF          = '0;
        bus.INSTRUCTION_IF = '0;
        bus.IF_ID_write    = 1'b0;
        bus.flush          = 1'b0;
        model_reset();

        // Reset values while reset is held
        reset = 1'b1;
        #3;
        check_all("reset");
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Three pushes drain in order with the ID stage advancing
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, "order");
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain");

        // Stalled ID fills the queue; fifth push is refused
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, "fill");
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "release");

        // Flush with a same-cycle push of 0x40 discards everything
        step(1'b1, 32'h200, 1'b0, 1'b0, "pre_fl");
        step(1'b1, 32'h204, 1'b0, 1'b0, "pre_fl");
        step(1'b1, 32'h40,  1'b1, 1'b1, "flush");
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "post_fl");
        chk("no_pc_40", 32'(saw_40), 32'h0);

        // Push into an empty queue while ID advances
        step(1'b1, 32'h10, 1'b1, 1'b0, "bypass");
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "byp_tail");

        // Streaming push/pop across several pointer wraps
        for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, "stream");
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "str_tail");

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), "rand");

        // Asynchronous reset in the middle of a burst with three entries queued
        step(1'b0, 32'h0, 1'b1, 1'b1, "clr");
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0, "burst");
        bus.push_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2 reset = 1'b0;
        step(1'b1, 32'h400, 1'b1, 1'b0, "after_rst");
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
